// File: rtl/controller_pkg.sv
//------------------------------------------------------------------------------
// controller_pkg: shared types and encodings for the multicycle Armv4 controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        LINK     = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/condition_unit.sv
//------------------------------------------------------------------------------
// condition_unit: registered NZCV flags, gated flag writes, cond_ex evaluation
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module condition_unit
    import controller_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              write_nz,
    input  logic              write_cv,
    output logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    cond_t cond_code;
    logic  n, z, c, v;

    assign cond_code = cond_t'(cond);
    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    // Writes are gated by the instruction's own condition, evaluated on the old flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (cond_ex) begin
            if (write_nz) begin
                flags[N_BIT] <= alu_flags[N_BIT];
                flags[Z_BIT] <= alu_flags[Z_BIT];
            end
            if (write_cv) begin
                flags[C_BIT] <= alu_flags[C_BIT];
                flags[V_BIT] <= alu_flags[V_BIT];
            end
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond_code)
            EQ: cond_ex = z;
            NE: cond_ex = !z;
            CS: cond_ex = c;
            CC: cond_ex = !c;
            MI: cond_ex = n;
            PL: cond_ex = !n;
            VS: cond_ex = v;
            VC: cond_ex = !v;
            HI: cond_ex = c && !z;
            LS: cond_ex = !c || z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = !z && (n == v);
            LE: cond_ex = z || (n != v);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// multicycle_controller: Armv4 multicycle main FSM plus condition unit.
// Optional MULTICYCLE_BL_EN adds a LINK state for BL. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
    import controller_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int FLAG_W     = 4,
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [FLAG_W-1:0]     ALU_flags,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  address_source,
    output logic                  write_instruction,
    output logic                  write_memory,
    output logic                  write_register,
    output logic [1:0]            register_source,
    output logic [1:0]            immediate_source,
    output logic                  ALU_source_a,
    output logic [1:0]            ALU_source_b,
    output logic [ALU_CTRL_W-1:0] ALU_control,
    output logic [1:0]            result_source,
    output logic [FLAG_W-1:0]     flags
);

    state_t     state, next_state;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       imm_bit, s_bit, l_bit, link_bit;
    logic [1:0] cmd_alu, alu_ctrl;
    logic       cmd_valid, cmd_arith, cmd_cmp;
    logic       in_exec, write_nz, write_cv, cond_ex;
    logic       unused_instr;

    assign op       = instruction[27:26];
    assign imm_bit  = instruction[25];
    assign cmd      = instruction[24:21];
    assign link_bit = instruction[24];
    assign s_bit    = instruction[20];
    assign l_bit    = instruction[20];
    // Register numbers and immediates are consumed by the datapath
    assign unused_instr = ^instruction;

    always_comb begin
        cmd_alu   = ALU_ADD;
        cmd_valid = 1'b1;
        cmd_arith = 1'b1;
        cmd_cmp   = 1'b0;
        case (cmd)
            CMD_ADD: cmd_alu = ALU_ADD;
            CMD_SUB: cmd_alu = ALU_SUB;
            CMD_CMP: begin cmd_alu = ALU_SUB; cmd_cmp = 1'b1; end
            CMD_AND: begin cmd_alu = ALU_AND; cmd_arith = 1'b0; end
            CMD_ORR: begin cmd_alu = ALU_ORR; cmd_arith = 1'b0; end
            default: begin cmd_valid = 1'b0; cmd_arith = 1'b0; end
        endcase
    end

    assign in_exec  = (state == EXECR) || (state == EXECI);
    assign write_nz = in_exec && s_bit && cmd_valid;
    assign write_cv = write_nz && cmd_arith;

    condition_unit #(.FLAG_W(FLAG_W)) u_cond (
        .clock     (clock),
        .reset     (reset),
        .cond      (instruction[31:28]),
        .alu_flags (ALU_flags),
        .write_nz  (write_nz),
        .write_cv  (write_cv),
        .flags     (flags),
        .cond_ex   (cond_ex)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state        = state;
        pc_write          = 1'b0;
        address_source    = 1'b0;
        write_instruction = 1'b0;
        write_memory      = 1'b0;
        write_register    = 1'b0;
        register_source   = 2'b00;
        immediate_source  = IMM_8;
        ALU_source_a      = 1'b0;
        ALU_source_b      = SRCB_REG;
        alu_ctrl          = ALU_ADD;
        result_source     = RES_ALUOUT;
        case (state)
            FETCH: begin
                ALU_source_a  = 1'b1;
                ALU_source_b  = SRCB_FOUR;
                result_source = RES_ALU;
                if (mem_ready) begin
                    write_instruction = 1'b1;
                    pc_write          = 1'b1;
                    next_state        = DECODE;
                end
            end
            DECODE: begin
                ALU_source_a    = 1'b1;
                ALU_source_b    = SRCB_FOUR;
                register_source = {(op == OP_MEM) && !l_bit, op == OP_BR};
                case (op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = imm_bit ? EXECI : EXECR;
`ifdef MULTICYCLE_BL_EN
                    OP_BR:   next_state = link_bit ? LINK : BRANCH;
`else
                    OP_BR:   next_state = BRANCH;
`endif
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: begin
                ALU_source_b     = SRCB_IMM;
                immediate_source = IMM_12;
                next_state       = l_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                address_source = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_source  = RES_MEM;
                write_register = cond_ex;
                next_state     = FETCH;
            end
            MEMWRITE: begin
                // A failed condition still consumes one memory handshake
                address_source = 1'b1;
                write_memory   = cond_ex;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                alu_ctrl   = cmd_alu;
                next_state = ALUWB;
            end
            EXECI: begin
                ALU_source_b = SRCB_IMM;
                alu_ctrl     = cmd_alu;
                next_state   = ALUWB;
            end
            ALUWB: begin
                write_register = cond_ex && cmd_valid && !cmd_cmp;
                next_state     = FETCH;
            end
`ifdef MULTICYCLE_BL_EN
            LINK: begin
                ALU_source_a   = 1'b1;
                ALU_source_b   = SRCB_FOUR;
                alu_ctrl       = ALU_SUB;
                result_source  = RES_ALU;
                write_register = cond_ex;
                next_state     = BRANCH;
            end
`endif
            BRANCH: begin
                ALU_source_b     = SRCB_IMM;
                immediate_source = IMM_24;
                register_source  = 2'b01;
                result_source    = RES_ALU;
                pc_write         = cond_ex;
                next_state       = FETCH;
            end
            default: next_state = FETCH;
        endcase
        // Reset silences every control line combinationally, aborting any access
        if (!reset) begin
            pc_write          = 1'b0;
            address_source    = 1'b0;
            write_instruction = 1'b0;
            write_memory      = 1'b0;
            write_register    = 1'b0;
            register_source   = 2'b00;
            immediate_source  = 2'b00;
            ALU_source_a      = 1'b0;
            ALU_source_b      = 2'b00;
            alu_ctrl          = 2'b00;
            result_source     = 2'b00;
        end
    end

    assign ALU_control = ALU_CTRL_W'(alu_ctrl);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//------------------------------------------------------------------------------
// tb_multicycle_controller: per-cycle vector table with scoreboard for the
// multicycle controller. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  ALU_flags;
    logic        mem_ready;
    logic        pc_write, address_source, write_instruction, write_memory, write_register;
    logic [1:0]  register_source, immediate_source, ALU_source_b, ALU_control, result_source;
    logic        ALU_source_a;
    logic [3:0]  flags;

    multicycle_controller #(.INSTR_W(32), .FLAG_W(4), .ALU_CTRL_W(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .instruction       (instruction),
        .ALU_flags         (ALU_flags),
        .mem_ready         (mem_ready),
        .pc_write          (pc_write),
        .address_source    (address_source),
        .write_instruction (write_instruction),
        .write_memory      (write_memory),
        .write_register    (write_register),
        .register_source   (register_source),
        .immediate_source  (immediate_source),
        .ALU_source_a      (ALU_source_a),
        .ALU_source_b      (ALU_source_b),
        .ALU_control       (ALU_control),
        .result_source     (result_source),
        .flags             (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] tag;
        logic [31:0] instr;
        logic [3:0]  alu_flags;
        logic        mr;
        logic [15:0] ctrl;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] ctrl_now;
    assign ctrl_now = {pc_write, address_source, write_instruction, write_memory, write_register,
                       register_source, immediate_source, ALU_source_a, ALU_source_b,
                       ALU_control, result_source};

    // Packs expected control lines in the same order as ctrl_now
    function automatic logic [15:0] c(input logic pcw, input logic as_, input logic wi,
                                      input logic wm, input logic wr, input logic [1:0] rs,
                                      input logic [1:0] is_, input logic sa, input logic [1:0] sb_,
                                      input logic [1:0] ac, input logic [1:0] res);
        return {pcw, as_, wi, wm, wr, rs, is_, sa, sb_, ac, res};
    endfunction

    task automatic chk(input logic [63:0] tag, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s row%0d: got %h expected %h", tag, idx, act, exp);
        end
    endtask

    task automatic add(input logic [63:0] tag, input logic [31:0] ins, input logic [3:0] af,
                       input logic mr, input logic [15:0] ctrl, input logic [3:0] fl);
        vec_t v;
        v.tag = tag; v.instr = ins; v.alu_flags = af; v.mr = mr; v.ctrl = ctrl; v.flags = fl;
        vecs.push_back(v);
    endtask

    logic [15:0] f_stall, f_go, d_dp, d_br, d_st, madr, mrd, mwb, mwr;
    logic [15:0] exr_add, exr_sub, exr_and, exi_sub, awb1, awb0, br1, br0, lnk;
    localparam logic [3:0] X = 4'hF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t exp_v;
        f_stall = c(0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,2'd2);
        f_go    = c(1,0,1,0,0,2'd0,2'd0,1,2'd2,2'd0,2'd2);
        d_dp    = c(0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,2'd0);
        d_br    = c(0,0,0,0,0,2'd1,2'd0,1,2'd2,2'd0,2'd0);
        d_st    = c(0,0,0,0,0,2'd2,2'd0,1,2'd2,2'd0,2'd0);
        madr    = c(0,0,0,0,0,2'd0,2'd1,0,2'd1,2'd0,2'd0);
        mrd     = c(0,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd0);
        mwb     = c(0,0,0,0,1,2'd0,2'd0,0,2'd0,2'd0,2'd1);
        mwr     = c(0,1,0,1,0,2'd0,2'd0,0,2'd0,2'd0,2'd0);
        exr_add = c(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd0);
        exr_sub = c(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd1,2'd0);
        exr_and = c(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd2,2'd0);
        exi_sub = c(0,0,0,0,0,2'd0,2'd0,0,2'd1,2'd1,2'd0);
        awb1    = c(0,0,0,0,1,2'd0,2'd0,0,2'd0,2'd0,2'd0);
        awb0    = 16'h0000;
        br1     = c(1,0,0,0,0,2'd1,2'd2,0,2'd1,2'd0,2'd2);
        br0     = c(0,0,0,0,0,2'd1,2'd2,0,2'd1,2'd0,2'd2);
        lnk     = c(0,0,0,0,1,2'd0,2'd0,1,2'd2,2'd1,2'd2);

        // ADD with a fetch stall first
        add("ADD",  32'hE0821003, X, 0, f_stall, 4'h0);
        add("ADD",  32'hE0821003, X, 1, f_go,    4'h0);
        add("ADD",  32'hE0821003, X, 1, d_dp,    4'h0);
        add("ADD",  32'hE0821003, X, 1, exr_add, 4'h0);
        add("ADD",  32'hE0821003, X, 1, awb1,    4'h0);
        // LDR with two wait states
        add("LDR",  32'hE5921004, X, 1, f_go,    4'h0);
        add("LDR",  32'hE5921004, X, 1, d_dp,    4'h0);
        add("LDR",  32'hE5921004, X, 1, madr,    4'h0);
        add("LDR",  32'hE5921004, X, 0, mrd,     4'h0);
        add("LDR",  32'hE5921004, X, 0, mrd,     4'h0);
        add("LDR",  32'hE5921004, X, 1, mrd,     4'h0);
        add("LDR",  32'hE5921004, X, 1, mwb,     4'h0);
        // SUBS sets Z, ADDEQ writes
        add("SUBS", 32'hE2500001, X,     1, f_go,    4'h0);
        add("SUBS", 32'hE2500001, X,     1, d_dp,    4'h0);
        add("SUBS", 32'hE2500001, 4'h4,  1, exi_sub, 4'h0);
        add("SUBS", 32'hE2500001, X,     1, awb1,    4'h4);
        add("ADDEQ",32'h00821003, X,     1, f_go,    4'h4);
        add("ADDEQ",32'h00821003, X,     1, d_dp,    4'h4);
        add("ADDEQ",32'h00821003, X,     1, exr_add, 4'h4);
        add("ADDEQ",32'h00821003, X,     1, awb1,    4'h4);
        // SUBS clears flags, ADDEQ suppressed
        add("SUBS0",32'hE2500001, X,     1, f_go,    4'h4);
        add("SUBS0",32'hE2500001, X,     1, d_dp,    4'h4);
        add("SUBS0",32'hE2500001, 4'h0,  1, exi_sub, 4'h4);
        add("SUBS0",32'hE2500001, X,     1, awb1,    4'h0);
        add("ADDEQ0",32'h00821003, X,    1, f_go,    4'h0);
        add("ADDEQ0",32'h00821003, X,    1, d_dp,    4'h0);
        add("ADDEQ0",32'h00821003, X,    1, exr_add, 4'h0);
        add("ADDEQ0",32'h00821003, X,    1, awb0,    4'h0);
        // Branches
        add("B",    32'hEA000002, X, 1, f_go, 4'h0);
        add("B",    32'hEA000002, X, 1, d_br, 4'h0);
        add("B",    32'hEA000002, X, 1, br1,  4'h0);
        add("BEQ",  32'h0A000002, X, 1, f_go, 4'h0);
        add("BEQ",  32'h0A000002, X, 1, d_br, 4'h0);
        add("BEQ",  32'h0A000002, X, 1, br0,  4'h0);
        add("BL",   32'hEB000001, X, 1, f_go, 4'h0);
        add("BL",   32'hEB000001, X, 1, d_br, 4'h0);
`ifdef MULTICYCLE_BL_EN
        add("BL",   32'hEB000001, X, 1, lnk,  4'h0);
`endif
        add("BL",   32'hEB000001, X, 1, br1,  4'h0);
        // CMP writes flags only; ANDS keeps C,V
        add("CMP",  32'hE1500001, X,    1, f_go,    4'h0);
        add("CMP",  32'hE1500001, X,    1, d_dp,    4'h0);
        add("CMP",  32'hE1500001, 4'h6, 1, exr_sub, 4'h0);
        add("CMP",  32'hE1500001, X,    1, awb0,    4'h6);
        add("ANDS", 32'hE0100002, X,    1, f_go,    4'h6);
        add("ANDS", 32'hE0100002, X,    1, d_dp,    4'h6);
        add("ANDS", 32'hE0100002, 4'h9, 1, exr_and, 4'h6);
        add("ANDS", 32'hE0100002, X,    1, awb1,    4'hA);
        add("ADDLT",32'hB0821003, X,    1, f_go,    4'hA);
        add("ADDLT",32'hB0821003, X,    1, d_dp,    4'hA);
        add("ADDLT",32'hB0821003, X,    1, exr_add, 4'hA);
        add("ADDLT",32'hB0821003, X,    1, awb1,    4'hA);
        add("ADDGT",32'hC0821003, X,    1, f_go,    4'hA);
        add("ADDGT",32'hC0821003, X,    1, d_dp,    4'hA);
        add("ADDGT",32'hC0821003, X,    1, exr_add, 4'hA);
        add("ADDGT",32'hC0821003, X,    1, awb0,    4'hA);
        // Undefined op returns straight to FETCH
        add("UND",  32'hEC000000, X, 1, f_go,    4'hA);
        add("UND",  32'hEC000000, X, 1, d_dp,    4'hA);
        add("UND",  32'hEC000000, X, 0, f_stall, 4'hA);
        // Never-condition store still waits for one handshake
        add("STRNV",32'hF5821004, X, 1, f_go,    4'hA);
        add("STRNV",32'hF5821004, X, 1, d_st,    4'hA);
        add("STRNV",32'hF5821004, X, 1, madr,    4'hA);
        add("STRNV",32'hF5821004, X, 0, mrd,     4'hA);
        add("STRNV",32'hF5821004, X, 1, mrd,     4'hA);
        add("STRNV",32'hF5821004, X, 0, f_stall, 4'hA);
        // Store left pending for the reset-abort sequence
        add("STR",  32'hE5821004, X, 1, f_go,    4'hA);
        add("STR",  32'hE5821004, X, 1, d_st,    4'hA);
        add("STR",  32'hE5821004, X, 1, madr,    4'hA);
        add("STR",  32'hE5821004, X, 0, mwr,     4'hA);

        // Reset held with mem_ready high: every output silent
        reset = 1'b0; mem_ready = 1'b1; instruction = 32'hE0821003; ALU_flags = X;
        repeat (2) @(negedge clock);
        #1;
        chk("RST_CTL", 0, ctrl_now, 16'h0000);
        chk("RST_FLG", 0, {12'h0, flags}, 16'h0000);
        mem_ready = 1'b0;
        reset     = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            instruction = vecs[i].instr;
            ALU_flags   = vecs[i].alu_flags;
            mem_ready   = vecs[i].mr;
            sb.push_back(vecs[i]);
            #1;
            exp_v = sb.pop_front();
            chk(exp_v.tag, i, ctrl_now, exp_v.ctrl);
            chk(exp_v.tag, i, {12'h0, flags}, {12'h0, exp_v.flags});
        end

        // Abort the pending store with an asynchronous reset
        #1 reset = 1'b0;
        #1;
        chk("ABORT_WM",  0, {15'h0, write_memory}, 16'h0000);
        chk("ABORT_CTL", 0, ctrl_now, 16'h0000);
        chk("ABORT_FLG", 0, {12'h0, flags}, 16'h0000);
        @(negedge clock);
        mem_ready = 1'b1;
        reset     = 1'b1;
        #1;
        chk("POST_FETCH", 0, ctrl_now, f_go);
        chk("POST_FLG",   0, {12'h0, flags}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
